fetch_line_unit: RTL and testbench

- Parametrised successor to the single-request instruction fetcher.
- Owns the fetch PC and a one-line instruction buffer filled by AXI INCR bursts.
- Serves sequential instructions from the buffer to decode over a valid/ready handshake.
- Handles branch redirects, including discarding (draining) an in-flight burst. Sits between the branch unit/decode and the AXI read port.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_line_buffer.sv | 39 +++
 rtl/fetch_line_unit.sv | 191 +++++++++++++++++++
 tb/tb_fetch_line_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and derived-size helpers for the line-buffered instruction fetcher.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_AR    = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Byte-offset width of one line (LINE_BEATS beats of DATA_W bits).
  function automatic int unsigned line_off_f(input int unsigned beats, input int unsigned data_w);
    return $clog2(beats * data_w / 8);
  endfunction

  function automatic logic [2:0] arsize_f(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// One-line instruction store: beat-granular write port, instruction-granular read mux.
module fetch_line_buffer #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned INSN_W     = 32,
  parameter int unsigned LINE_BEATS = 8,
  parameter int unsigned BEAT_W     = $clog2(LINE_BEATS),
  parameter int unsigned WORD_W     = $clog2(LINE_BEATS * DATA_W / INSN_W)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [BEAT_W-1:0] wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [WORD_W-1:0] rd_word_i,
  output logic [INSN_W-1:0] rd_insn_o
);

  localparam int unsigned WPB = DATA_W / INSN_W;

  logic [DATA_W-1:0] mem_q [LINE_BEATS];
  logic [BEAT_W-1:0] rd_beat;
  logic [DATA_W-1:0] rd_data;
  int unsigned       rd_sub;

  // Storage holds data only; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Lower instruction address sits in the lower bits of a beat.
  always_comb begin
    rd_beat   = BEAT_W'(rd_word_i / WORD_W'(WPB));
    rd_sub    = 32'(rd_word_i % WORD_W'(WPB));
    rd_data   = mem_q[rd_beat];
    rd_insn_o = INSN_W'(rd_data >> (rd_sub * INSN_W));
  end

endmodule

// File: rtl/fetch_line_unit.sv
// Fetch PC owner with a one-line buffer refilled by AXI INCR bursts; redirects drain in-flight fills.
// Optional build macro FETCH_PERF_EN adds saturating hit/miss/redirect counters.
module fetch_line_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       INSN_W     = 32,
  parameter int unsigned       LINE_BEATS = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(64'h0)
) (
`ifdef FETCH_PERF_EN
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       redirect_cnt,
`endif
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_insn,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic              m_axi_rlast
);

  localparam int unsigned LINE_OFF = line_off_f(LINE_BEATS, DATA_W);
  localparam int unsigned WORD_W   = LINE_OFF - 2;
  localparam int unsigned BEAT_W   = $clog2(LINE_BEATS);
  localparam int unsigned TAG_W    = ADDR_W - LINE_OFF;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              line_valid_q, line_valid_d;
  logic              redir_pend_q, redir_pend_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [TAG_W-1:0]  pc_tag;
  logic              hit;
  logic              out_valid_c;
  logic              out_fire;
  logic              buf_we;
  logic [INSN_W-1:0] buf_insn;

  // The buffered line's tag is the address of the last issued AR.
  assign pc_tag      = pc_q[ADDR_W-1:LINE_OFF];
  assign hit         = line_valid_q && (pc_tag == araddr_q[ADDR_W-1:LINE_OFF]);
  assign out_valid_c = (state_q == ST_RUN) && hit && fetch_enable && !redirect_valid;
  assign out_fire    = out_valid_c && out_ready;

  assign out_valid     = out_valid_c;
  assign out_pc        = out_valid_c ? pc_q : '0;
  assign out_insn      = out_valid_c ? buf_insn : '0;
  assign busy          = (state_q != ST_RUN);
  assign m_axi_arvalid = (state_q == ST_AR);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_rready  = (state_q == ST_DATA) || (state_q == ST_DRAIN);
  assign m_axi_arlen   = 8'(LINE_BEATS - 1);
  assign m_axi_arsize  = arsize_f(DATA_W);
  assign m_axi_arburst = AXI_BURST_INCR;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      araddr_q     <= '0;
      line_valid_q <= 1'b0;
      redir_pend_q <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      araddr_q     <= araddr_d;
      line_valid_q <= line_valid_d;
      redir_pend_q <= redir_pend_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Redirect updates the PC in every state; the state machine only decides the fill fate.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    araddr_d     = araddr_q;
    line_valid_d = line_valid_q;
    redir_pend_d = redir_pend_q;
    beat_cnt_d   = beat_cnt_q;
    buf_we       = 1'b0;

    if (redirect_valid) begin
      pc_d = redirect_pc & ~ADDR_W'(3);
    end

    unique case (state_q)
      ST_RUN: begin
        if (!redirect_valid && fetch_enable) begin
          if (hit) begin
            if (out_ready) begin
              pc_d = pc_q + ADDR_W'(4);
            end
          end else begin
            state_d      = ST_AR;
            araddr_d     = {pc_tag, {LINE_OFF{1'b0}}};
            line_valid_d = 1'b0;
          end
        end
      end
      ST_AR: begin
        if (redirect_valid) begin
          redir_pend_d = 1'b1;
        end
        if (m_axi_arready) begin
          state_d      = (redirect_valid || redir_pend_q) ? ST_DRAIN : ST_DATA;
          redir_pend_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (m_axi_rvalid) begin
          buf_we     = 1'b1;
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
        if (m_axi_rvalid && m_axi_rlast) begin
          state_d      = ST_RUN;
          beat_cnt_d   = '0;
          line_valid_d = !redirect_valid;
        end else if (redirect_valid) begin
          state_d    = ST_DRAIN;
          beat_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (m_axi_rvalid && m_axi_rlast) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  fetch_line_buffer #(
    .DATA_W    (DATA_W),
    .INSN_W    (INSN_W),
    .LINE_BEATS(LINE_BEATS),
    .BEAT_W    (BEAT_W),
    .WORD_W    (WORD_W)
  ) u_buf (
    .clk      (clk),
    .wr_en_i  (buf_we),
    .wr_idx_i (beat_cnt_q),
    .wr_data_i(m_axi_rdata),
    .rd_word_i(pc_q[LINE_OFF-1:2]),
    .rd_insn_o(buf_insn)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      redirect_cnt <= '0;
    end else begin
      if (out_fire && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (m_axi_arvalid && m_axi_arready && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
      if (redirect_valid && (redirect_cnt != '1)) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_fire;
  assign unused_fire = out_fire;
`endif

endmodule

// File: tb/tb_fetch_line_unit.sv
// Directed bench for fetch_line_unit: AXI slave model plus scoreboards of expected PCs and AR addresses.
module tb_fetch_line_unit;

  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned INSN_W     = 32;
  localparam int unsigned LINE_BEATS = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_enable;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INSN_W-1:0] out_insn;
  logic [ADDR_W-1:0] out_pc;
  logic              busy;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic              m_axi_rlast;
`ifdef FETCH_PERF_EN
  logic [31:0]       hit_cnt, miss_cnt, redirect_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] exp_pc_q[$];
  logic [ADDR_W-1:0] exp_ar_q[$];

  // Slave model state
  int                s_active = 0;
  int                s_beat   = 0;
  int                ar_wait  = 0;
  int                ar_delay = 0;
  logic [ADDR_W-1:0] s_addr   = '0;

  always #5 clk = ~clk;

  fetch_line_unit #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INSN_W    (INSN_W),
    .LINE_BEATS(LINE_BEATS),
    .RESET_PC  (64'h1000)
  ) dut (
`ifdef FETCH_PERF_EN
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .redirect_cnt  (redirect_cnt),
`endif
    .clk           (clk),
    .reset         (reset),
    .fetch_enable  (fetch_enable),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_insn      (out_insn),
    .out_pc        (out_pc),
    .busy          (busy),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rlast   (m_axi_rlast)
  );

  function automatic logic [31:0] insn_of(input logic [63:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      n++;
    end
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  // AXI read slave: drives at posedge+1, samples handshakes at negedge.
  initial begin
    logic ar_hs, r_hs, arv;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rdata   = '0;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      arv   = m_axi_arvalid;
      @(posedge clk);
      #1;
      if (reset !== 1'b1) begin
        s_active = 0;
        s_beat   = 0;
        ar_wait  = 0;
      end else begin
        if (r_hs) begin
          if (s_beat == int'(LINE_BEATS) - 1) s_active = 0;
          s_beat++;
        end
        if (ar_hs) begin
          s_active = 1;
          s_beat   = 0;
          s_addr   = m_axi_araddr;
          ar_wait  = 0;
        end else if (arv) begin
          ar_wait++;
        end
      end
      m_axi_arready = (reset === 1'b1) && (s_active == 0) && (ar_wait >= ar_delay);
      m_axi_rvalid  = (s_active != 0);
      m_axi_rlast   = (s_active != 0) && (s_beat == int'(LINE_BEATS) - 1);
      m_axi_rdata   = {insn_of(s_addr + 64'(s_beat * 8) + 64'd4), insn_of(s_addr + 64'(s_beat * 8))};
    end
  end

  // Scoreboard monitor: every accepted instruction and AR must match the next queued expectation.
  always @(negedge clk) begin
    logic [ADDR_W-1:0] e;
    if (reset === 1'b1 && out_valid && out_ready) begin
      total++;
      assert (exp_pc_q.size() > 0) else begin
        bad++;
        $error("FAIL out_unexpected observed_pc=%h expected=no_handshake", out_pc);
      end
      if (exp_pc_q.size() > 0) begin
        e = exp_pc_q.pop_front();
        chk("out_pc", out_pc, e);
        chk("out_insn", 64'(out_insn), 64'(insn_of(e)));
      end
    end
    if (reset === 1'b1 && m_axi_arvalid && m_axi_arready) begin
      total++;
      assert (exp_ar_q.size() > 0) else begin
        bad++;
        $error("FAIL ar_unexpected observed_addr=%h expected=no_ar", m_axi_araddr);
      end
      if (exp_ar_q.size() > 0) begin
        e = exp_ar_q.pop_front();
        chk("araddr", m_axi_araddr, e);
        chk("arlen", 64'(m_axi_arlen), 64'd7);
        chk("arsize", 64'(m_axi_arsize), 64'd3);
        chk("arburst", 64'(m_axi_arburst), 64'd1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset          = 1'b0;
    fetch_enable   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_rready", 64'(m_axi_rready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_arlen", 64'(m_axi_arlen), 64'd7);
    chk("rst_arsize", 64'(m_axi_arsize), 64'd3);
    chk("rst_arburst", 64'(m_axi_arburst), 64'd1);

    // fetch_enable low: a miss must not issue an AR
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fe0_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("fe0_out_valid", 64'(out_valid), 64'd0);
      step();
    end

    // First fill, 16 instructions, then sequential crossing into 0x1040
    exp_ar_q.push_back(64'h1000);
    exp_ar_q.push_back(64'h1040);
    for (int i = 0; i <= 16; i++) exp_pc_q.push_back(64'h1000 + 64'(i * 4));
    fetch_enable = 1'b1;
    out_ready    = 1'b1;
    n = 0;
    while (exp_pc_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    fetch_enable = 1'b0;
    out_ready    = 1'b0;
    chk("fill_pc_left", 64'(exp_pc_q.size()), 64'd0);
    chk("fill_ar_left", 64'(exp_ar_q.size()), 64'd0);

    // Redirect to 0x2006 while beat 3 of a fill is on the bus
    fetch_enable   = 1'b1;
    exp_ar_q.push_back(64'h3000);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    step();
    redirect_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_axi_rvalid && m_axi_rready && s_beat == 2) && n < 200);
    chk("beat2_seen", 64'(s_beat), 64'd2);
    step();
    exp_ar_q.push_back(64'h2000);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2006;
    @(negedge clk);
    chk("redir_beat3_rready", 64'(m_axi_rready), 64'd1);
    chk("redir_beat3_valid", 64'(out_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    wait_out_valid("redir_timeout");
    chk("redir_pc", out_pc, 64'h2004);
    chk("redir_insn", 64'(out_insn), 64'(insn_of(64'h2004)));
    chk("redir_ar_left", 64'(exp_ar_q.size()), 64'd0);

    // Back-pressure on a hit: outputs held stable
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_pc", out_pc, 64'h2004);
      chk("hold_insn", 64'(out_insn), 64'(insn_of(64'h2004)));
    end
    exp_pc_q.push_back(64'h2004);
    exp_pc_q.push_back(64'h2008);
    step();
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("hold_pc_left", 64'(exp_pc_q.size()), 64'd0);
    chk("after_hold_pc", out_pc, 64'h200C);

    // Redirect into the buffered line beats a same-cycle handshake and needs no AR
    step();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2032;
    @(negedge clk);
    chk("redir_hs_valid", 64'(out_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    @(negedge clk);
    chk("inline_valid", 64'(out_valid), 64'd1);
    chk("inline_pc", out_pc, 64'h2030);
    chk("inline_insn", 64'(out_insn), 64'(insn_of(64'h2030)));

    // arready held low while redirects pulse: AR held, then drained, then target line
    step();
    ar_delay       = 4;
    exp_ar_q.push_back(64'h5000);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h5000;
    step();
    redirect_valid = 1'b0;
    step();
    exp_ar_q.push_back(64'h6000);
    for (int i = 0; i < 4; i++) begin
      redirect_valid = (i == 0) || (i == 2);
      redirect_pc    = 64'h6008;
      @(negedge clk);
      chk("arhold_arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("arhold_araddr", m_axi_araddr, 64'h5000);
      step();
    end
    redirect_valid = 1'b0;
    ar_delay       = 0;
    wait_out_valid("drain_timeout");
    chk("drain_pc", out_pc, 64'h6008);
    chk("drain_insn", 64'(out_insn), 64'(insn_of(64'h6008)));
    chk("drain_ar_left", 64'(exp_ar_q.size()), 64'd0);

    // Reset in the middle of a fill
    step();
    exp_ar_q.push_back(64'h7000);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h7000;
    step();
    redirect_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_axi_rvalid && m_axi_rready && s_beat == 4) && n < 200);
    chk("beat4_seen", 64'(s_beat), 64'd4);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("midrst_rready", 64'(m_axi_rready), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    step();
    step();
    exp_ar_q.push_back(64'h1000);
    reset = 1'b1;
    wait_out_valid("postrst_timeout");
    chk("postrst_pc", out_pc, 64'h1000);
    chk("postrst_insn", 64'(out_insn), 64'(insn_of(64'h1000)));
    chk("postrst_ar_left", 64'(exp_ar_q.size()), 64'd0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
